alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that borrows the shared Hack ALU.
// Latency: done asserts 1 + popcount(b) + msb_index(b) cycles after start (1..32).
// Backpressure: start is honoured only in IDLE; pulses while busy are dropped.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start, a, b         - request and two's-complement operands (captured on accept)
//   busy, done          - busy in ACC/DBL/DONE; done is a one-cycle result strobe
//   result, res_zr/ng   - low WIDTH bits of a*b plus zero/negative flags
//   alu_x/alu_y, alu_zx..alu_no, alu_out - operand, control and return path of the ALU
module alu_mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_zr,
  output logic             res_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, ACC, DBL, DONE} state_t;

  // {zx, nx, zy, ny, f, no}
  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ADD  = 6'b000010;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic [5:0]       ctl;
  logic [WIDTH-1:0] mp_shr;

  assign mp_shr = mp_q >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      result_q <= '0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      result_q <= result_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    result_d = result_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    alu_x    = '0;
    alu_y    = '0;
    ctl      = CTL_ZERO;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          mc_d  = a;
          mp_d  = b;
          if (b == '0)     state_d = DONE;
          else if (b[0])   state_d = ACC;
          else             state_d = DBL;
        end
      end
      ACC: begin
        busy  = 1'b1;
        alu_x = acc_q;
        alu_y = mc_q;
        ctl   = CTL_ADD;
        acc_d = alu_out;
        // mp is not shifted here; the following DBL does that.
        state_d = (mp_shr == '0) ? DONE : DBL;
      end
      DBL: begin
        busy  = 1'b1;
        alu_x = mc_q;
        alu_y = mc_q;
        ctl   = CTL_ADD;
        mc_d  = alu_out;
        mp_d  = mp_shr;
        if (mp_shr == '0)  state_d = DONE;
        else if (mp_shr[0]) state_d = ACC;
        else               state_d = DBL;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        result_d = acc_q;
        zr_d     = (acc_q == '0);
        ng_d     = acc_q[WIDTH-1];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bypass acc during DONE so the product is visible alongside the done strobe;
  // the registered copy takes over from the next cycle on.
  assign result = (state_q == DONE) ? acc_q : result_q;
  assign res_zr = (state_q == DONE) ? (acc_q == '0) : zr_q;
  assign res_ng = (state_q == DONE) ? acc_q[WIDTH-1] : ng_q;

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctl;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, res_zr, res_ng;
  logic [15:0] result, alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  alu_mul_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .res_zr(res_zr), .res_ng(res_ng),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // Behavioural Hack ALU standing in for the shared instance.
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = alu_zx ? 16'h0000 : alu_x;
    if (alu_nx) ax = ~ax;
    ay = alu_zy ? 16'h0000 : alu_y;
    if (alu_ny) ay = ~ay;
    ao = alu_f ? (ax + ay) : (ax & ay);
    if (alu_no) ao = ~ao;
    alu_out = ao;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] held = 16'h0000;

  // Monitor: pops the scoreboard on every done and checks result hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held = 16'h0000;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
        chk("res_zr", {31'd0, res_zr}, {31'd0, (e.res == 16'h0000)});
        chk("res_ng", {31'd0, res_ng}, {31'd0, e.res[15]});
        chk("latency", cyc - e.start_cyc, e.lat);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        held = e.res;
      end
    end else begin
      chk("result_hold", {16'd0, result}, {16'd0, held});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] eres, input int lat, input bit push);
    exp_t e;
    start = 1'b1;
    a = ia;
    b = ib;
    if (push) begin
      e.res = eres;
      e.start_cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 64) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  // Issue, wait for done, then step into the IDLE cycle right after it.
  task automatic run(input string name, input logic [15:0] ia, input logic [15:0] ib,
                     input logic [15:0] eres, input int lat);
    issue(ia, ib, eres, lat, 1'b1);
    wait_done(name);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_res_zr", {31'd0, res_zr}, 32'd1);
    chk("rst_res_ng", {31'd0, res_ng}, 32'd0);
    chk("rst_alu_ctl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'b101010);
    chk("rst_alu_x", {16'd0, alu_x}, 32'd0);
    chk("rst_alu_y", {16'd0, alu_y}, 32'd0);
    reset = 1'b0;
    tick();

    run("3x5",       16'd3,     16'd5,     16'd15,    5);
    run("m3x7",      16'hFFFD,  16'd7,     16'hFFEB,  6);
    run("wrap256",   16'h0100,  16'h0100,  16'h0000,  10);
    run("bzero",     16'd1234,  16'd0,     16'h0000,  1);
    run("min_x_min", 16'h8000,  16'h8000,  16'h0000,  17);
    run("neg1sq",    16'hFFFF,  16'hFFFF,  16'h0001,  32);
    run("100xm2",    16'd100,   16'hFFFE,  16'hFF38,  31);
    run("ffx3",      16'h00FF,  16'd3,     16'h02FD,  4);

    // Maximum-latency run with stray starts while busy, then back-to-back start.
    issue(16'h7FFF, 16'hFFFF, 16'h8001, 32, 1'b1);
    tick();
    issue(16'd5, 16'd5, 16'd0, 0, 1'b0);
    repeat (8) tick();
    issue(16'd9, 16'd1, 16'd0, 0, 1'b0);
    wait_done("maxlat");
    tick();
    run("b2b",       16'd2,     16'd2,     16'd4,     3);

    // Abort a long run with reset at cycle 10.
    issue(16'h1234, 16'hFFFF, 16'd0, 0, 1'b0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_res_zr", {31'd0, res_zr}, 32'd1);
    repeat (40) tick();
    run("post_abort", 16'd2,    16'd2,     16'd4,     3);

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
